// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared funct constants and mul/div state encodings
package mips_pkg;

  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } step_mode_e;

  function automatic logic is_muldiv(input logic [5:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
           (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one shift-add or restoring trial-subtract iteration
module muldiv_step
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  step_mode_e         mode,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // MUL: {upper, multiplier} shifts right; DIV: {remainder, dividend/quotient} shifts left.
  always_comb begin
    acc_next = '0;
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    ge       = rem_sh >= {1'b0, operand};
    diff     = rem_sh[WIDTH-1:0] - operand;
    if (mode == STEP_MUL) begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end else if (ge) begin
      acc_next = {diff, acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
module alu_muldiv
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  md_state_e          state, state_next;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, acc_next, prod;
  logic [WIDTH-1:0]   opnd;
  step_mode_e         mode;
  logic               neg_q, neg_r, div_zero;

  logic               req, accept, op_signed, op_div, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, quo, rem, res_hi, res_lo;

  assign req       = (state == ST_IDLE) && start && !flush;
  assign accept    = req && is_muldiv(funct);
  assign op_signed = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
  assign op_div    = (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
  assign a_neg     = op_signed && a[WIDTH-1];
  assign b_neg     = op_signed && b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;
  assign busy      = (state != ST_IDLE);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .operand  (opnd),
    .mode     (mode),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = ST_RUN;
      ST_RUN: begin
        if (flush)          state_next = ST_IDLE;
        else if (cnt == '0) state_next = ST_FIX;
      end
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Sign fix-up: a divide by zero leaves the remainder equal to the dividend magnitude,
  // so only the quotient needs forcing to all ones.
  always_comb begin
    prod   = neg_q ? -acc : acc;
    quo    = acc[WIDTH-1:0];
    rem    = acc[2*WIDTH-1:WIDTH];
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (mode == STEP_DIV) begin
      res_lo = div_zero ? '1 : (neg_q ? -quo : quo);
      res_hi = neg_r ? -rem : rem;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      opnd     <= '0;
      mode     <= STEP_MUL;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        acc      <= {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
        opnd     <= op_div ? b_mag : a_mag;
        mode     <= op_div ? STEP_DIV : STEP_MUL;
        cnt      <= CW'(WIDTH - 1);
        neg_q    <= a_neg ^ b_neg;
        neg_r    <= a_neg;
        div_zero <= op_div && (b == '0);
      end else if (req && funct == FUNCT_MTHI) begin
        hi <= a;
      end else if (req && funct == FUNCT_MTLO) begin
        lo <= a;
      end else if (state == ST_RUN && !flush) begin
        acc <= acc_next;
        cnt <= cnt - 1'b1;
      end else if (state == ST_FIX && !flush) begin
        hi   <= res_hi;
        lo   <= res_lo;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb/tb_alu_muldiv.sv - scoreboard bench for alu_muldiv at WIDTH=32
module tb_alu_muldiv;
  import mips_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [5:0]   funct = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         flush = 1'b0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  typedef struct {
    string        tag;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  alu_muldiv #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .funct (funct),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    longint      sp;
    logic [63:0] up;
    int          sq, sr;
    case (f)
      FUNCT_MULT: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        return sp;
      end
      FUNCT_MULTU: begin
        up = {32'b0, x} * {32'b0, y};
        return up;
      end
      FUNCT_DIV: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sq = $signed(x) / $signed(y);
        sr = $signed(x) % $signed(y);
        return {sr, sq};
      end
      FUNCT_DIVU: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      default: return '0;
    endcase
  endfunction

  task automatic push(input string tag, input logic [W-1:0] ehi, input logic [W-1:0] elo);
    exp_t e;
    e.tag = tag;
    e.hi  = ehi;
    e.lo  = elo;
    sb.push_back(e);
  endtask

  // Called at a negedge; the request is sampled at the following posedge.
  task automatic issue(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    funct = f;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered one half-cycle after the accept edge; returns in the done cycle.
  task automatic wait_done();
    int   cyc = 1;
    int   busyc = 0;
    exp_t e;
    while (!done && cyc < 200) begin
      if (busy) busyc++;
      @(negedge clk);
      cyc++;
    end
    check("done_seen", done, 1'b1);
    check("latency", cyc - 1, W + 1);
    check("busy_cycles", busyc, W + 1);
    check("busy_low_at_done", busy, 1'b0);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1'b1, 1'b0);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_hi"}, hi, e.hi);
      check({e.tag, "_lo"}, lo, e.lo);
    end
  endtask

  initial begin
    logic [63:0] r;
    logic [W-1:0] x, y, save_hi, save_lo;
    logic [5:0]  f;
    int          dones, busys;

    repeat (3) @(negedge clk);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    rst_n = 1'b1;

    @(negedge clk);
    push("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);
    issue(FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done();
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);

    push("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    issue(FUNCT_MULT, 32'hFFFF_FFFD, 32'd7);
    wait_done();
    @(negedge clk);
    push("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(FUNCT_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done();
    @(negedge clk);
    push("divu_small", 32'd1, 32'd3);
    issue(FUNCT_DIVU, 32'd7, 32'd2);
    wait_done();
    @(negedge clk);
    push("divu_zero", 32'h0000_1234, 32'hFFFF_FFFF);
    issue(FUNCT_DIVU, 32'h0000_1234, 32'h0);
    wait_done();
    @(negedge clk);
    push("div_zero_neg", 32'hFFFF_FF00, 32'hFFFF_FFFF);
    issue(FUNCT_DIV, 32'hFFFF_FF00, 32'h0);
    wait_done();
    @(negedge clk);
    push("div_ovf", 32'h0, 32'h8000_0000);
    issue(FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done();

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      x = $urandom;
      y = (i == 7) ? 32'h0000_0003 : $urandom;
      case (i % 4)
        0: f = FUNCT_MULT;
        1: f = FUNCT_MULTU;
        2: f = FUNCT_DIV;
        default: f = FUNCT_DIVU;
      endcase
      r = model(f, x, y);
      push($sformatf("rand%0d", i), r[63:32], r[31:0]);
      issue(f, x, y);
      wait_done();
    end

    // Back-to-back: next request driven in the done cycle itself.
    @(negedge clk);
    push("b2b_first", 32'h0, 32'h0000_0C00);
    issue(FUNCT_MULTU, 32'd48, 32'd64);
    wait_done();
    push("b2b_second", 32'h0000_0001, 32'h0000_0000);
    issue(FUNCT_MULTU, 32'h0001_0000, 32'h0001_0000);
    wait_done();

    @(negedge clk);
    issue(FUNCT_MTHI, 32'hDEAD_BEEF, 32'h0);
    check("mthi_hi", hi, 32'hDEAD_BEEF);
    check("mthi_lo_kept", lo, 32'h0);
    check("mthi_busy", busy, 1'b0);
    check("mthi_done", done, 1'b0);
    issue(FUNCT_MTLO, 32'h1357_9BDF, 32'h0);
    check("mtlo_lo", lo, 32'h1357_9BDF);
    check("mtlo_busy", busy, 1'b0);

    issue(6'h20, 32'h1111_1111, 32'h2222_2222);
    check("ignored_busy", busy, 1'b0);
    check("ignored_hi", hi, 32'hDEAD_BEEF);
    check("ignored_lo", lo, 32'h1357_9BDF);

    flush = 1'b1;
    issue(FUNCT_MULT, 32'd5, 32'd6);
    flush = 1'b0;
    check("flush_start_busy", busy, 1'b0);

    save_hi = hi;
    save_lo = lo;
    issue(FUNCT_MULT, 32'd9, 32'd9);
    repeat (4) @(negedge clk);
    issue(FUNCT_MULTU, 32'd1, 32'd1);
    repeat (4) @(negedge clk);
    check("busy_before_flush", busy, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", busy, 1'b0);
    dones = 0;
    busys = 0;
    repeat (40) begin
      if (done) dones++;
      if (busy) busys++;
      @(negedge clk);
    end
    check("flush_no_done", dones, 0);
    check("flush_stays_idle", busys, 0);
    check("flush_hi_kept", hi, save_hi);
    check("flush_lo_kept", lo, save_lo);

    issue(FUNCT_MULT, 32'd3, 32'd3);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_hi", hi, 32'h0);
    check("async_rst_lo", lo, 32'h0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push("after_reset", 32'd4, 32'd14);
    issue(FUNCT_DIVU, 32'd200, 32'd14);
    wait_done();

    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
